// File: rtl/img_pkg.sv
// Shared constants and state encoding for the frame read-back path.
// Read-back fetches a stored frame from DDR through a MIG read port.
package img_pkg;

  localparam logic [2:0] MIG_CMD_WRITE   = 3'b000;
  localparam logic [2:0] MIG_CMD_READ    = 3'b001;
  localparam int         BURST_LEN       = 32;
  localparam int         BURST_LEN_BYTES = 256;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2,
    S_LAST = 2'd3
  } img_state_e;

endpackage

// File: rtl/image_rd_if.sv
// Reads a stored frame back from DDR in fixed MIG read bursts and forwards the
// 64-bit words into the host output FIFO, never issuing more than it can absorb.
module image_rd_if #(
  parameter int BURST_LEN = 32,
  parameter int OB_DEPTH  = 1024,
  parameter int OB_CNT_W  = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [29:0]          start_addr,
  input  logic [15:0]          frame_bursts,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_cmd_en,
  output logic [2:0]           mem_cmd_instr,
  output logic [5:0]           mem_cmd_burst_len,
  output logic [29:0]          mem_cmd_byte_addr,
  input  logic                 mem_cmd_full,
  output logic                 mem_rd_en,
  input  logic [63:0]          mem_rd_data,
  input  logic                 mem_rd_empty,
  output logic                 ob_wr_en,
  output logic [63:0]          ob_din,
  input  logic [OB_CNT_W-1:0]  ob_wr_count,
  output img_pkg::img_state_e  state_dbg
);
  import img_pkg::*;

  localparam int                  WC_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [29:0]         ADDR_STEP = 30'(BURST_LEN * 8);
  localparam logic [WC_W-1:0]     LAST_WORD = WC_W'(BURST_LEN - 1);
  // One slot beyond the burst is reserved for the word still in the output register.
  localparam logic [OB_CNT_W-1:0] ISSUE_MAX = OB_CNT_W'(OB_DEPTH - BURST_LEN - 1);

  img_state_e      state, state_nxt;
  logic [29:0]     addr_reg, addr_nxt;
  logic [15:0]     bursts_left, bursts_nxt;
  logic [WC_W-1:0] word_cnt, word_cnt_nxt;
  logic            busy_r, busy_nxt;
  logic            zero_done, zero_done_nxt;

  assign mem_cmd_instr     = MIG_CMD_READ;
  assign mem_cmd_burst_len = 6'(BURST_LEN - 1);
  assign mem_cmd_byte_addr = addr_reg;
  assign busy              = busy_r;
  assign state_dbg         = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      addr_reg    <= '0;
      bursts_left <= '0;
      word_cnt    <= '0;
      busy_r      <= 1'b0;
      zero_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr_reg    <= addr_nxt;
      bursts_left <= bursts_nxt;
      word_cnt    <= word_cnt_nxt;
      busy_r      <= busy_nxt;
      zero_done   <= zero_done_nxt;
    end
  end

  // MIG handshake: a command transfers on a cycle with mem_cmd_en=1 and
  // mem_cmd_full=0; a read word transfers on a cycle with mem_rd_en=1, which is
  // only raised while mem_rd_empty=0, so every mem_rd_en is a completed pop.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr_reg;
    bursts_nxt    = bursts_left;
    word_cnt_nxt  = word_cnt;
    busy_nxt      = busy_r;
    zero_done_nxt = 1'b0;
    mem_cmd_en    = 1'b0;
    mem_rd_en     = 1'b0;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        if (zero_done) begin
          // Empty frame: finish without touching memory.
          done     = 1'b1;
          busy_nxt = 1'b0;
        end else if (start && !busy_r) begin
          addr_nxt   = start_addr;
          bursts_nxt = frame_bursts;
          busy_nxt   = 1'b1;
          if (frame_bursts == 16'd0) zero_done_nxt = 1'b1;
          else                       state_nxt     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mem_cmd_full && (ob_wr_count <= ISSUE_MAX)) begin
          mem_cmd_en   = 1'b1;
          addr_nxt     = addr_reg + ADDR_STEP;
          bursts_nxt   = bursts_left - 16'd1;
          word_cnt_nxt = '0;
          state_nxt    = S_READ;
        end
      end
      S_READ: begin
        if (!mem_rd_empty) begin
          mem_rd_en    = 1'b1;
          word_cnt_nxt = word_cnt + 1'b1;
          if (word_cnt == LAST_WORD)
            state_nxt = (bursts_left != 16'd0) ? S_WAIT : S_LAST;
        end
      end
      S_LAST: begin
        done      = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ob_wr_en <= 1'b0;
      ob_din   <= '0;
    end else begin
      ob_wr_en <= mem_rd_en;
      if (mem_rd_en) ob_din <= mem_rd_data;
    end
  end

endmodule

// File: doc/image_rd_if.md
Name: image_rd_if

Overview:
- Downstream neighbour of the frame-capture writer: once a frame has been stored to DDR, this block reads it back through a MIG read port.
- Reads are issued as fixed-length bursts starting at a given byte address.
- The 64-bit words are pushed into the host pipe-out FIFO.
- Read commands are throttled so the output FIFO can never overflow.

Parameters:
- BURST_LEN, 32, 64-bit words per MIG read command (bytes per command = BURST_LEN*8 = 256).
- OB_DEPTH, 1024, output FIFO depth in 64-bit words.
- OB_CNT_W, 11, width of output FIFO write-count input (holds 0..OB_DEPTH).

Ports:
- clk  in  1  system/MIG user clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begin reading a frame.
- start_addr  in  30  byte address of frame; sampled on accepted start; must be 256-byte aligned.
- frame_bursts  in  16  number of bursts in frame; sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the last word of the frame is written to the output FIFO.
- mem_cmd_en  out  1  MIG command strobe.
- mem_cmd_instr  out  3  constant 3'b001 (read).
- mem_cmd_burst_len  out  6  constant BURST_LEN-1.
- mem_cmd_byte_addr  out  30  command address.
- mem_cmd_full  in  1  MIG command FIFO full.
- mem_rd_en  out  1  pop MIG read FIFO.
- mem_rd_data  in  64  MIG read data; valid while mem_rd_empty=0.
- mem_rd_empty  in  1  MIG read FIFO empty.
- ob_wr_en  out  1  output FIFO write.
- ob_din  out  64  output FIFO data.
- ob_wr_count  in  OB_CNT_W  words currently in output FIFO.

Behaviour:
- Reset (reset_n=0 at clk edge):
  - All outputs low/zero; mem_cmd_instr and mem_cmd_burst_len stay constant.
  - State S_IDLE; internal counters cleared.
  - Reset mid-frame abandons the frame: no done, and no further cmd/rd_en.
- S_IDLE:
  - start=1 latches start_addr into addr_reg and frame_bursts into bursts_left; busy<=1.
  - If frame_bursts==0: done pulses the next cycle, busy returns low, state stays S_IDLE.
  - Otherwise go to S_WAIT.
  - start while busy is ignored.
- S_WAIT:
  - Issue when mem_cmd_full==0 and ob_wr_count <= OB_DEPTH-BURST_LEN-1; the extra slot covers the in-flight registered word.
  - On issue, for exactly one cycle: mem_cmd_en=1 with mem_cmd_byte_addr=addr_reg.
  - Same edge: addr_reg += 256, bursts_left -= 1, word_cnt <= 0, go to S_READ.
- S_READ:
  - mem_rd_en = (mem_rd_empty==0) combinationally; pop the word present that cycle.
  - On each pop, word_cnt += 1.
  - When the pop is word BURST_LEN-1: go to S_WAIT if bursts_left!=0, else S_LAST.
  - Exactly BURST_LEN pops per command; a gap in mem_rd_empty stalls without loss.
  - At most one command is outstanding.
- Data path:
  - Registered: ob_wr_en <= mem_rd_en; ob_din <= mem_rd_data when mem_rd_en.
  - Latency 1 cycle from pop to FIFO write.
- S_LAST (one cycle):
  - Final ob_wr_en occurs.
  - done=1 this cycle, busy<=0, go to S_IDLE.
- Address arithmetic: 30-bit unsigned, wraps modulo 2^30 without error.
- Frame size per frame: frame_bursts*BURST_LEN words.
- ob_wr_count is assumed to lag writes by up to 1 cycle; the threshold absorbs this.

Decomposition:
- Shared package (img_pkg): MIG_CMD_WRITE=3'b000, MIG_CMD_READ=3'b001, BURST_LEN, BURST_LEN_BYTES=256, state encodings.
- Single module; no sub-module warranted.

Test Plan:
- start_addr=0x100, frame_bursts=2, FIFO empty, MIG returns data immediately:
  - two mem_cmd_en pulses, at 0x100 and 0x200;
  - 64 ob_wr_en with data matching the MIG sequence;
  - done exactly one cycle after the 64th pop, then busy=0.
- frame_bursts=0 -> no mem_cmd_en; done one cycle after start; busy high for exactly one cycle.
- ob_wr_count=OB_DEPTH-BURST_LEN (992) held -> no command issued; drop to 991 -> mem_cmd_en the next cycle.
- mem_cmd_full=1 for 10 cycles in S_WAIT -> mem_cmd_en deferred until it clears; the address is unchanged.
- mem_rd_empty toggled every other cycle during a burst -> exactly 32 pops; ob_din ordering preserved; no extra rd_en.
- reset_n=0 mid-burst (after 10 pops) -> all outputs 0 next cycle; no done. A new start after release reads from the new start_addr.
